// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM state encodings and op-class helpers shared by the
// md_unit_param multiply/divide unit.
package md_pkg;

   typedef logic [3:0] md_op_t;

   localparam md_op_t MD_MULT  = 4'd0;
   localparam md_op_t MD_MULTU = 4'd1;
   localparam md_op_t MD_DIV   = 4'd2;
   localparam md_op_t MD_DIVU  = 4'd3;
   localparam md_op_t MD_MADD  = 4'd4;
   localparam md_op_t MD_MADDU = 4'd5;
   localparam md_op_t MD_MSUB  = 4'd6;
   localparam md_op_t MD_MSUBU = 4'd7;
   localparam md_op_t MD_MTHI  = 4'd8;
   localparam md_op_t MD_MTLO  = 4'd9;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_MUL      = 3'd1;
   localparam logic [2:0] ST_DIV_PRE  = 3'd2;
   localparam logic [2:0] ST_DIV_ITER = 3'd3;
   localparam logic [2:0] ST_DIV_POST = 3'd4;

   function automatic logic is_mul(input md_op_t op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
             (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
   endfunction

   function automatic logic is_div(input md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_signed_op(input md_op_t op);
      return (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/md_div_iter.sv
// md_div_iter: unsigned restoring divider core, one quotient bit per step.
// load captures the operands; WIDTH steps later quotient/remainder are final.
module md_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;

   // The dividend shifts out of quo_q MSB-first while quotient bits shift in.
   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvs_q};
      if (load) begin
         rem_d = '0;
         quo_d = dividend;
         dvs_d = divisor;
      end else if (step) begin
         if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/md_unit_param.sv
// md_unit_param: HI/LO multiply/divide unit (mult, madd/msub, restoring div, mthi/mtlo).
// Optional MDU_CANCEL_EN adds a cancel input that flushes an in-flight operation.
module md_unit_param
   import md_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5,
   parameter int OP_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MDU_CANCEL_EN
  ,input  logic             cancel
`endif
);

   localparam int DW      = 2 * WIDTH;
   localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   md_op_t           op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [DW-1:0]    prod_q, prod_d;
   logic             div_zero_q, div_zero_d;
   logic             div_ovf_q, div_ovf_d;

   md_op_t           op_code;
   logic             op_known;
   logic             start_ok;
   logic [DW-1:0]    acc;

   // Upper op bits beyond the package encoding must be zero for a defined op.
   generate
      if (OP_W > 4) begin : g_op_wide
         assign op_code  = op[3:0];
         assign op_known = ~|op[OP_W-1:4];
      end else begin : g_op_narrow
         assign op_code  = 4'(op);
         assign op_known = 1'b1;
      end
   endgenerate

`ifdef MDU_CANCEL_EN
   assign start_ok = start & op_known & ~cancel;
`else
   assign start_ok = start & op_known;
`endif

   // Product is formed from the live operands at the accepting edge.
   logic signed [DW-1:0] a_sx, b_sx;
   logic        [DW-1:0] prod_sgn, prod_uns;
   assign a_sx     = {{WIDTH{a[WIDTH-1]}}, a};
   assign b_sx     = {{WIDTH{b[WIDTH-1]}}, b};
   assign prod_sgn = a_sx * b_sx;
   assign prod_uns = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   logic             div_sgn, a_neg, b_neg;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH-1:0] quo, rem;
   logic             div_load, div_step;

   assign div_sgn = is_signed_op(op_q);
   assign a_neg   = div_sgn & a_q[WIDTH-1];
   assign b_neg   = div_sgn & b_q[WIDTH-1];
   assign dvd_mag = a_neg ? -a_q : a_q;
   assign dvs_mag = b_neg ? -b_q : b_q;

   md_div_iter #(
      .WIDTH (WIDTH)
   ) u_div (
      .clk       (clk),
      .load      (div_load),
      .step      (div_step),
      .dividend  (dvd_mag),
      .divisor   (dvs_mag),
      .quotient  (quo),
      .remainder (rem)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      prod_d     = prod_q;
      div_zero_d = div_zero_q;
      div_ovf_d  = div_ovf_q;
      div_load   = 1'b0;
      div_step   = 1'b0;
      acc        = {hi_q, lo_q};

      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               if (is_mul(op_code)) begin
                  state_d = ST_MUL;
                  cnt_d   = MUL_CNT0;
                  op_d    = op_code;
                  prod_d  = is_signed_op(op_code) ? prod_sgn : prod_uns;
               end else if (is_div(op_code)) begin
                  state_d = ST_DIV_PRE;
                  op_d    = op_code;
                  a_d     = a;
                  b_d     = b;
               end else if (op_code == MD_MTHI) begin
                  hi_d = a;
               end else if (op_code == MD_MTLO) begin
                  lo_d = a;
               end
            end
         end

         // Accumulation reads HI/LO at the final write, not at start.
         ST_MUL: begin
            if (cnt_q == '0) begin
               case (op_q)
                  MD_MADD, MD_MADDU: acc = {hi_q, lo_q} + prod_q;
                  MD_MSUB, MD_MSUBU: acc = {hi_q, lo_q} - prod_q;
                  default:           acc = prod_q;
               endcase
               hi_d    = acc[DW-1:WIDTH];
               lo_d    = acc[WIDTH-1:0];
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_DIV_PRE: begin
            div_load   = 1'b1;
            div_zero_d = (b_q == '0);
            div_ovf_d  = div_sgn && (a_q == MIN_VAL) && (b_q == '1);
            cnt_d      = DIV_CNT0;
            state_d    = ST_DIV_ITER;
         end

         ST_DIV_ITER: begin
            div_step = 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_DIV_POST;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         // Magnitude results get their signs back here.
         ST_DIV_POST: begin
            if (div_zero_q) begin
               lo_d = '1;
               hi_d = a_q;
            end else if (div_ovf_q) begin
               lo_d = MIN_VAL;
               hi_d = '0;
            end else begin
               lo_d = (a_neg ^ b_neg) ? -quo : quo;
               hi_d = a_neg ? -rem : rem;
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

`ifdef MDU_CANCEL_EN
      if (cancel && (state_q != ST_IDLE)) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         hi_d     = hi_q;
         lo_d     = lo_q;
         done_d   = 1'b0;
         div_load = 1'b0;
         div_step = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Operand and product holding registers carry no reset.
   always_ff @(posedge clk) begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      prod_q     <= prod_d;
      div_zero_q <= div_zero_d;
      div_ovf_q  <= div_ovf_d;
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
// Bench for md_unit_param: directed cases plus randomized ops compared each cycle
// against a latency/result model; define MDU_CANCEL_EN to also exercise cancel.
`timescale 1ns/1ps
module tb_md_unit_param;
   import md_pkg::*;

   localparam int WIDTH   = 32;
   localparam int MUL_LAT = 5;
   localparam int OP_W    = 4;
   localparam int DIV_LAT = WIDTH + 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              cancel = 1'b0;
   logic [OP_W-1:0]   op = '0;
   logic [WIDTH-1:0]  a = '0;
   logic [WIDTH-1:0]  b = '0;
   logic              busy, done;
   logic [WIDTH-1:0]  hi, lo;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   md_unit_param #(
      .WIDTH   (WIDTH),
      .MUL_LAT (MUL_LAT),
      .OP_W    (OP_W)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
`ifdef MDU_CANCEL_EN
     ,.cancel (cancel)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Architectural result of one operation from plain integer arithmetic.
   function automatic void ref_result(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] h, input logic [31:0] l,
                                      output logic [31:0] nh, output logic [31:0] nl);
      logic [63:0] acc, p;
      longint sx, sy, q, r;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      acc = {h, l};
      p   = 64'(sx * sy);
      if (o == MD_MULTU || o == MD_MADDU || o == MD_MSUBU)
         p = {32'd0, x} * {32'd0, y};
      nh = h;
      nl = l;
      case (o)
         MD_MULT, MD_MULTU: {nh, nl} = p;
         MD_MADD, MD_MADDU: {nh, nl} = acc + p;
         MD_MSUB, MD_MSUBU: {nh, nl} = acc - p;
         MD_DIV: begin
            if (y == 0) begin
               nl = 32'hFFFF_FFFF; nh = x;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               nl = 32'h8000_0000; nh = 32'h0;
            end else begin
               q = sx / sy; r = sx % sy;
               nl = q[31:0]; nh = r[31:0];
            end
         end
         MD_DIVU: begin
            if (y == 0) begin
               nl = 32'hFFFF_FFFF; nh = x;
            end else begin
               nl = x / y; nh = x % y;
            end
         end
         default: ;
      endcase
   endfunction

   // Model: cycles left busy, pending result, and a one-cycle done flag.
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   int          m_left = 0;
   logic        m_done = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            if (cancel) begin
               m_left = 0;
            end else begin
               m_left--;
               if (m_left == 0) begin
                  m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
               end
            end
         end else if (start && !cancel) begin
            if (op <= 4'd7) begin
               ref_result(op, a, b, m_hi, m_lo, p_hi, p_lo);
               m_left = (op == MD_DIV || op == MD_DIVU) ? DIV_LAT : MUL_LAT;
            end else if (op == MD_MTHI) begin
               m_hi = a;
            end else if (op == MD_MTLO) begin
               m_lo = a;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_busy", 64'(busy), 64'(m_left > 0));
         chk("cyc_done", 64'(done), 64'(m_done));
         chk("cyc_hi", 64'(hi), 64'(m_hi));
         chk("cyc_lo", 64'(lo), 64'(m_lo));
      end
   end

   task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = OP_W'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic wait_done(input string name, input int exp_busy);
      int nb;
      bit seen;
      nb = 0; seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) nb++;
         @(negedge clk);
      end
      chk({name, "_done_seen"}, 64'(seen), 64'd1);
      chk({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] eh, el;
      int          nd;
      logic [3:0]  ro;

      // Model pins: hand-computed results.
      ref_result(MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, eh, el);
      chk("model_mult", {eh, el}, 64'hFFFF_FFFF_FFFF_FFFA);
      ref_result(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, eh, el);
      chk("model_div", {eh, el}, 64'hFFFF_FFFF_FFFF_FFFD);
      ref_result(MD_MSUBU, 32'd3, 32'd4, 32'd0, 32'd5, eh, el);
      chk("model_msubu", {eh, el}, 64'hFFFF_FFFF_FFFF_FFF9);

      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      wait_done("mult", MUL_LAT);
      chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);

      do_op(MD_MTHI, 32'd0, 32'd0);
      do_op(MD_MTLO, 32'd10, 32'd0);
      do_op(MD_MADDU, 32'hFFFF_FFFF, 32'd2);
      wait_done("maddu", MUL_LAT);
      chk("maddu_hi", 64'(hi), 64'd2);
      chk("maddu_lo", 64'(lo), 64'd8);

      do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done("div", DIV_LAT);
      chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
      chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

      do_op(MD_DIVU, 32'd7, 32'd0);
      wait_done("divu0", DIV_LAT);
      chk("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
      chk("divu0_hi", 64'(hi), 64'd7);

      do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      repeat (5) @(negedge clk);
      do_op(MD_MTLO, 32'h1234_5678, 32'd0);
      wait_done("divovf", DIV_LAT - 6);
      chk("divovf_lo", 64'(lo), 64'h8000_0000);
      chk("divovf_hi", 64'(hi), 64'd0);

      do_op(4'hF, 32'h5555_5555, 32'd1);
      chk("undef_busy", 64'(busy), 64'd0);

      do_op(MD_DIV, 32'd100, 32'd3);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("rstmid_busy", 64'(busy), 64'd0);
      chk("rstmid_hi", 64'(hi), 64'd0);
      chk("rstmid_lo", 64'(lo), 64'd0);
      nd = 0;
      repeat (40) begin
         if (done) nd++;
         @(negedge clk);
      end
      chk("rstmid_no_done", 64'(nd), 64'd0);

      do_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
      wait_done("b2b_mul", MUL_LAT);
      chk("b2b_mul_hi", 64'(hi), 64'd1);
      chk("b2b_mul_lo", 64'(lo), 64'd0);
      do_op(MD_DIVU, 32'd100, 32'd7);
      wait_done("b2b_div", DIV_LAT);
      chk("b2b_div_lo", 64'(lo), 64'd14);
      chk("b2b_div_hi", 64'(hi), 64'd2);

`ifdef MDU_CANCEL_EN
      do_op(MD_MULT, 32'd9, 32'd9);
      @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy", 64'(busy), 64'd0);
      chk("cancel_hi", 64'(hi), 64'd2);
      chk("cancel_lo", 64'(lo), 64'd14);
      nd = 0;
      repeat (10) begin
         if (done) nd++;
         @(negedge clk);
      end
      chk("cancel_no_done", 64'(nd), 64'd0);
`endif

      for (int k = 0; k < 400; k++) begin
         ro = 4'($urandom_range(0, 15));
         do_op(ro, pick(), pick());
         repeat ($urandom_range(0, 40)) @(negedge clk);
         if ($urandom_range(0, 49) == 0) begin
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
         end
      end

      nd = 0;
      while (busy && nd < 100) begin
         nd++;
         @(negedge clk);
      end
      chk("final_idle", 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
